// File: rtl/dmem_resp.sv
// Data-memory responder for the M-stage load/store port: word RAM with byte-lane
// write merge, fixed wait states, one-cycle ready pulse. Macro DMEM_ERR_EN adds err_o.
module dmem_resp #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  we_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        stall_o
`ifdef DMEM_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dmem_resp: WAIT_CYCLES must be in 0..15");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_base_align
        $warning("dmem_resp: BASE_ADDR is not word aligned");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q;
    logic [3:0]        we_q;
    logic [31:0]       wdata_q;
    logic              oor_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [DEPTH];

    logic              accept, commit;
    logic [ADDR_W-1:0] in_idx, c_idx;
    logic [3:0]        c_we;
    logic [31:0]       c_wdata;
    logic              in_oor, c_oor;
    logic              unused_addr;

    assign in_idx      = addr_i[ADDR_W+1:2];
    assign unused_addr = ^{addr_i[1:0], addr_i[31:ADDR_W+2]};

`ifdef DMEM_ERR_EN
    localparam logic [32:0] SPAN = 33'(1) << (ADDR_W + 2);
    logic [32:0] offset;
    logic        err_q;
    // Addresses below the base wrap to a set bit 32, so one compare covers both ends.
    assign offset = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    assign in_oor = (offset >= SPAN);
    assign err_o  = err_q;
`else
    assign in_oor = 1'b0;
`endif

    // With zero wait states the commit edge is the accept edge, so the live inputs are used.
    assign c_idx   = (state_q == S_IDLE) ? in_idx  : idx_q;
    assign c_we    = (state_q == S_IDLE) ? we_i    : we_q;
    assign c_wdata = (state_q == S_IDLE) ? wdata_i : wdata_q;
    assign c_oor   = (state_q == S_IDLE) ? in_oor  : oor_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i && !flush_i) begin
                    accept = 1'b1;
                    cnt_d  = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 4'd0;
            wdata_q <= 32'd0;
            oor_q   <= 1'b0;
            rdata_q <= 32'd0;
`ifdef DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= in_idx;
                we_q    <= we_i;
                wdata_q <= wdata_i;
                oor_q   <= in_oor;
            end
            // Read-before-write: a store returns the word as it was before the merge.
            if (commit) begin
                rdata_q <= c_oor ? 32'd0 : mem[c_idx];
`ifdef DMEM_ERR_EN
                err_q   <= c_oor;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && !c_oor) begin
            for (int n = 0; n < 4; n++) begin
                if (c_we[n]) mem[c_idx][8*n +: 8] <= c_wdata[8*n +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;
    assign ready_o = (state_q == S_RESP);
    assign stall_o = req_i & ~ready_o & ~flush_i;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: instance 0 with two wait states, instance 1 with none,
// directed vector table, hand-written flush/reset sequences, then random traffic.
module tb_dmem_resp;

    localparam int WCS [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        flush [2];
    logic        ready [2];
    logic        stall [2];
    logic [3:0]  we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
`ifdef DMEM_ERR_EN
    logic        err   [2];
`endif

    always #5 clk = ~clk;

    dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
        .wdata_i(wdata[0]), .flush_i(flush[0]), .rdata_o(rdata[0]),
        .ready_o(ready[0]), .stall_o(stall[0])
`ifdef DMEM_ERR_EN
        , .err_o(err[0])
`endif
    );

    dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
        .wdata_i(wdata[1]), .flush_i(flush[1]), .rdata_o(rdata[1]),
        .ready_o(ready[1]), .stall_o(stall[1])
`ifdef DMEM_ERR_EN
        , .err_o(err[1])
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // reference memory per instance; vld marks words whose contents are fully known
    logic [31:0] mdl [2][1024];
    bit          vld [2][1024];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got %h, expected %h", nm, d, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit oor(input logic [31:0] a);
`ifdef DMEM_ERR_EN
        return a >= 32'h0000_1000;
`else
        return (a != a);
`endif
    endfunction

    // Applies an access to the reference memory; returns the expected rdata.
    task automatic model_acc(input int d, input logic [31:0] a, input logic [3:0] w,
                             input logic [31:0] wd, output bit known, output logic [31:0] exp);
        int idx;
        idx = int'(a[11:2]);
        if (oor(a)) begin
            known = 1'b1;
            exp   = 32'd0;
            return;
        end
        known = vld[d][idx];
        exp   = mdl[d][idx];
        for (int n = 0; n < 4; n++)
            if (w[n]) mdl[d][idx][8*n +: 8] = wd[8*n +: 8];
        if (w == 4'hF) vld[d][idx] = 1'b1;
    endtask

    // Starts at a cycle boundary; response must arrive exactly WAIT+1 cycles after issue.
    task automatic run_access(input int d, input logic [31:0] a, input logic [3:0] w,
                              input logic [31:0] wd, input bit chk_rd,
                              input logic [31:0] exp_rd, input bit fl_resp);
        int wc;
        wc = WCS[d];
        req[d] = 1'b1; addr[d] = a; we[d] = w; wdata[d] = wd; flush[d] = 1'b0;
        for (int c = 0; c <= wc + 1; c++) begin
            if (c > 0) tick();
            if (c == wc + 1 && fl_resp) flush[d] = 1'b1;
            @(negedge clk);
            chk("ready", d, 32'(ready[d]), 32'(c == wc + 1));
            chk("stall", d, 32'(stall[d]), 32'(c != wc + 1));
            if (c == wc + 1) begin
                if (chk_rd) chk("rdata", d, rdata[d], exp_rd);
`ifdef DMEM_ERR_EN
                chk("err", d, 32'(err[d]), 32'(oor(a)));
`endif
            end
        end
        tick();
        req[d] = 1'b0; flush[d] = 1'b0; we[d] = 4'd0;
    endtask

    // Issue, then flush at cycle fc (inside WAIT); access must vanish.
    task automatic flush_access(input int d, input logic [31:0] a, input logic [3:0] w,
                                input logic [31:0] wd, input int fc);
        req[d] = 1'b1; addr[d] = a; we[d] = w; wdata[d] = wd; flush[d] = 1'b0;
        for (int c = 0; c <= fc; c++) begin
            if (c > 0) tick();
            if (c == fc) flush[d] = 1'b1;
            @(negedge clk);
            chk("flush_ready", d, 32'(ready[d]), 32'd0);
            chk("flush_stall", d, 32'(stall[d]), 32'(c != fc));
        end
        tick();
        req[d] = 1'b0; flush[d] = 1'b0; we[d] = 4'd0;
    endtask

    task automatic acc(input int d, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] wd, input bit fl_resp);
        bit          known;
        logic [31:0] exp;
        model_acc(d, a, w, wd, known, exp);
        run_access(d, a, w, wd, known, exp, fl_resp);
    endtask

    typedef struct {
        int          d;
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [14];
        bit          known;
        logic [31:0] exp, a;
        logic [3:0]  w;
        int          d, wi, r;

        tbl[0]  = '{0, 32'h10, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
        tbl[1]  = '{0, 32'h10, 4'h0, 32'h0,         1'b1, 32'h1122_3344};
        tbl[2]  = '{0, 32'h20, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[3]  = '{0, 32'h20, 4'h2, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF};
        tbl[4]  = '{0, 32'h20, 4'h0, 32'h0,         1'b1, 32'hDEAD_55EF};
        tbl[5]  = '{0, 32'h23, 4'h0, 32'h0,         1'b1, 32'hDEAD_55EF};
        tbl[6]  = '{0, 32'h40, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
        tbl[7]  = '{0, 32'h44, 4'hF, 32'h0102_0304, 1'b0, 32'h0};
        tbl[8]  = '{0, 32'h44, 4'h5, 32'hA5A5_A5A5, 1'b1, 32'h0102_0304};
        tbl[9]  = '{0, 32'h44, 4'h0, 32'h0,         1'b1, 32'h01A5_03A5};
        tbl[10] = '{1, 32'h10, 4'hF, 32'hA1B2_C3D4, 1'b0, 32'h0};
        tbl[11] = '{1, 32'h10, 4'h0, 32'h0,         1'b1, 32'hA1B2_C3D4};
        tbl[12] = '{1, 32'h12, 4'hC, 32'h9988_7766, 1'b1, 32'hA1B2_C3D4};
        tbl[13] = '{1, 32'h10, 4'h0, 32'h0,         1'b1, 32'h9988_C3D4};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; flush[i] = 1'b0; we[i] = 4'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        repeat (3) tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, 32'(ready[i]), 32'd0);
            chk("rst_rdata", i, rdata[i], 32'd0);
            chk("rst_stall", i, 32'(stall[i]), 32'd0);
`ifdef DMEM_ERR_EN
            chk("rst_err", i, 32'(err[i]), 32'd0);
`endif
        end
        tick();
        rst = 1'b0;
        tick();

        // directed table, entries issued back to back
        foreach (tbl[i]) begin
            model_acc(tbl[i].d, tbl[i].a, tbl[i].w, tbl[i].wd, known, exp);
            run_access(tbl[i].d, tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].chk_rd, tbl[i].exp, 1'b0);
        end

        // flush in WAIT drops the store; the next request is accepted at cycle 2
        flush_access(0, 32'h40, 4'hF, 32'h0BAD_0BAD, 1);
        run_access(0, 32'h40, 4'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);

        // flush in RESP: commit already done
        acc(0, 32'h48, 4'hF, 32'h1357_9BDF, 1'b1);
        run_access(0, 32'h48, 4'h0, 32'h0, 1'b1, 32'h1357_9BDF, 1'b0);

        // flush in IDLE blocks acceptance
        req[0] = 1'b1; addr[0] = 32'h48; flush[0] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("idle_flush_ready", 0, 32'(ready[0]), 32'd0);
            chk("idle_flush_stall", 0, 32'(stall[0]), 32'd0);
            tick();
        end
        acc(0, 32'h48, 4'h0, 32'h0, 1'b0);

        // reset mid-store: store dropped, rdata cleared
        req[0] = 1'b1; addr[0] = 32'h40; we[0] = 4'hF; wdata[0] = 32'h1234_5678;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; req[0] = 1'b0; we[0] = 4'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_mid_ready", 0, 32'(ready[0]), 32'd0);
            chk("rst_mid_rdata", 0, rdata[0], 32'd0);
            tick();
        end
        run_access(0, 32'h40, 4'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);

`ifdef DMEM_ERR_EN
        run_access(0, 32'h0001_0000, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
        run_access(0, 32'h0000_1040, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
        run_access(0, 32'h40, 4'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
`endif

        // random traffic against the reference memory
        for (int i = 0; i < 300; i++) begin
            d  = i % 2;
            wi = $urandom_range(0, 31);
            a  = 32'(wi << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 15) << 12);
            if (!vld[d][int'(a[11:2])]) w = 4'hF;
            else if ($urandom_range(0, 2) == 0) w = 4'h0;
            else w = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (d == 0 && r == 0)
                flush_access(d, a, w, $urandom, $urandom_range(1, 2));
            else
                acc(d, a, w, $urandom, r == 1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("gap_ready", d, 32'(ready[d]), 32'd0);
                chk("gap_stall", d, 32'(stall[d]), 32'd0);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
